layer_0_controller: RTL and testbench
=====================================

LAYER_0_CONTROLLER -- requirements
Module: layer_0_controller

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 8: input image width and height in pixels (square image).
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: convolution window width and height.
REQ-003 SHALL have parameter PIPE_LAT, default 4: cycles from the last window issue until the last result is written.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port layer_0_en, input, 1 bit: layer run enable from the network manager, held high across images.
REQ-007 SHALL have port buf_ready, input, 1 bit: the image buffer can accept a read this cycle.
REQ-008 SHALL have port rd_en, output, 1 bit: image buffer read strobe.
REQ-009 SHALL have port rd_addr, output, logb2(IMAGE_SIZE*IMAGE_SIZE) bits: linear pixel address, row*IMAGE_SIZE+col.
REQ-010 SHALL have port calc_en, output, 1 bit: the window is complete and the PE array computes this cycle.
REQ-011 SHALL have port out_idx, output, logb2((IMAGE_SIZE-KERNEL_SIZE+1)^2) bits: linear index of the current output pixel.
REQ-012 SHALL have port layer_0_calc_fin, output, 1 bit: one-cycle pulse when the current image is finished.

Function
REQ-013 SHALL implement the states IDLE, SCAN, DRAIN and FIN.
REQ-014 SHALL move IDLE->SCAN on a cycle where layer_0_en=1, and otherwise stay in IDLE.
REQ-015 SHALL, in SCAN, drive rd_en=buf_ready and advance the pixel counter (col, then row) only on cycles where buf_ready=1.
REQ-016 SHALL hold the counters, rd_addr and the state when buf_ready=0; SCAN is frozen and no read is lost or duplicated.
REQ-017 SHALL assert calc_en exactly one cycle after a read of a pixel with row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 (buffer latency 1).
REQ-018 SHALL increment out_idx after each calc_en cycle, giving (IMAGE_SIZE-KERNEL_SIZE+1)^2 calc_en pulses per image.
REQ-019 SHALL go SCAN->DRAIN on the accepted read of address IMAGE_SIZE^2-1, and SHALL wrap the counters to 0 on that read.
REQ-020 SHALL stay in DRAIN for exactly PIPE_LAT cycles, with rd_en=0 and no stall applied.
REQ-021 SHALL go DRAIN->FIN, where FIN lasts one cycle with layer_0_calc_fin=1, then FIN->IDLE unconditionally.
REQ-022 SHALL make IDLE start the next image one cycle after FIN when layer_0_en is still high; the manager drops enable on the last image's fin edge.
REQ-023 SHALL abort to IDLE on layer_0_en=0 in SCAN or DRAIN: counters and out_idx cleared, no fin pulse.
REQ-024 SHALL ignore layer_0_en in FIN.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-026 SHALL, on rst_n=0, immediately set state=IDLE, all counters=0, rd_en=0, rd_addr=0, calc_en=0, out_idx=0, layer_0_calc_fin=0.
REQ-027 SHALL treat reset in mid-image as an abort; the next image starts at address 0.

Structure
REQ-028 SHALL take logb2 and the state encoding localparams from the shared network parameter package (network_param).
REQ-029 SHALL contain one sub-module, pixel_scan_counter: row/col counter with enable and wrap, which outputs rd_addr and window_valid.

Verification
REQ-030 SHALL cover: IMAGE_SIZE=8, KERNEL_SIZE=3, PIPE_LAT=4, en held high, buf_ready=1 -> 64 reads at addresses 0..63, 36 calc_en pulses, fin in cycle 68 counting the first rd_en as cycle 0.
REQ-031 SHALL cover: buf_ready low for 5 cycles at address 20 -> address 20 held, no extra read, fin delayed by exactly 5 cycles.
REQ-032 SHALL cover: the manager with IMAGE_NUM=3 -> 3 fin pulses, a one-cycle IDLE gap between images, and the controller in IDLE after the 3rd fin.
REQ-033 SHALL cover: en dropped at address 30 -> IDLE the next cycle, no fin; re-enable -> scan restarts at address 0.
REQ-034 SHALL cover: rst_n asserted in DRAIN -> all outputs 0 asynchronously, with no fin pulse.
REQ-035 SHALL cover: first calc_en one cycle after the read of address 18 (row 2, col 2), with out_idx=0 on that cycle.

Source files
------------

// File: rtl/network_param.sv
`default_nettype none
// ============================================================================
//  Module      : network_param (package)
//  Description : Shared network parameters: controller state encoding and
//                the logb2 address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package network_param;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        DRAIN = ST_DRAIN,
        FIN   = ST_FIN
    } ctrl_state_t;

    // Bits needed to index 'value' distinct items (ceil(log2)), never below 1.
    function automatic int logb2(input int value);
        int v;
        int bits;
        v    = value - 1;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                bits = bits + 1;
                v    = v >> 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scan_counter
//  Description : Raster row/col counter over a square image. Advances col
//                first, then row, on inc; wraps to 0 after the last pixel.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                clr               - synchronous clear (abort)
//                inc               - advance to the next pixel
//                addr              - row*IMAGE_SIZE+col of the current pixel
//                window_valid      - current pixel completes a KxK window
//                last              - current pixel is the last of the image
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_scan_counter
    import network_param::*;
#(
    parameter int IMAGE_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    localparam int ADDR_W     = logb2(IMAGE_SIZE * IMAGE_SIZE),
    localparam int CNT_W      = logb2(IMAGE_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              window_valid,
    output logic              last
);

    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(KERNEL_SIZE - 1);

    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == MAX_IDX) begin
                col <= '0;
                row <= (row == MAX_IDX) ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    assign addr         = ADDR_W'(row) * ADDR_W'(IMAGE_SIZE) + ADDR_W'(col);
    assign window_valid = (row >= WIN_MIN) && (col >= WIN_MIN);
    assign last         = (row == MAX_IDX) && (col == MAX_IDX);

endmodule
`default_nettype wire

// File: rtl/layer_0_controller.sv
`default_nettype none
// ============================================================================
//  Module      : layer_0_controller
//  Description : Convolution layer-0 sequencer. Streams the image buffer in
//                raster order (stalling on buf_ready), flags each complete
//                KxK window one cycle after its last pixel is read, drains the
//                PE pipeline and pulses layer_0_calc_fin once per image.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                layer_0_en        - run enable (dropping it aborts)
//                buf_ready         - buffer can accept a read this cycle
//                rd_en, rd_addr    - buffer read strobe / linear address
//                calc_en, out_idx  - PE compute strobe / output pixel index
//                layer_0_calc_fin  - one-cycle end-of-image pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_0_controller
    import network_param::*;
#(
    parameter int IMAGE_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int PIPE_LAT    = 4,
    localparam int ADDR_W     = logb2(IMAGE_SIZE * IMAGE_SIZE),
    localparam int IDX_W      = logb2((IMAGE_SIZE - KERNEL_SIZE + 1) * (IMAGE_SIZE - KERNEL_SIZE + 1))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_0_en,
    input  logic              buf_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              calc_en,
    output logic [IDX_W-1:0]  out_idx,
    output logic              layer_0_calc_fin
);

    localparam int DRAIN_W = logb2(PIPE_LAT + 1);

    ctrl_state_t        state, state_nx;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    logic               rd_en_nx, calc_en_nx, fin_nx;
    logic [ADDR_W-1:0]  rd_addr_nx;
    logic [IDX_W-1:0]   out_idx_nx;
    // Attributes of the pixel whose read is currently on rd_addr.
    logic               win_q, win_nx;
    logic               last_q, last_nx;

    logic               scan_inc, scan_clr, abort;
    logic [ADDR_W-1:0]  scan_addr;
    logic               scan_win, scan_last;

    pixel_scan_counter #(
        .IMAGE_SIZE  (IMAGE_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (scan_clr),
        .inc          (scan_inc),
        .addr         (scan_addr),
        .window_valid (scan_win),
        .last         (scan_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            rd_en            <= 1'b0;
            rd_addr          <= '0;
            calc_en          <= 1'b0;
            out_idx          <= '0;
            layer_0_calc_fin <= 1'b0;
            win_q            <= 1'b0;
            last_q           <= 1'b0;
        end else begin
            state            <= state_nx;
            drain_cnt        <= drain_nx;
            rd_en            <= rd_en_nx;
            rd_addr          <= rd_addr_nx;
            calc_en          <= calc_en_nx;
            out_idx          <= out_idx_nx;
            layer_0_calc_fin <= fin_nx;
            win_q            <= win_nx;
            last_q           <= last_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        drain_nx   = drain_cnt;
        rd_en_nx   = 1'b0;
        rd_addr_nx = rd_addr;
        win_nx     = win_q;
        last_nx    = last_q;
        // The buffer returns data one cycle after the strobe, so the window
        // completed by the read on the outputs now is computed next cycle.
        calc_en_nx = rd_en & win_q;
        out_idx_nx = calc_en ? out_idx + IDX_W'(1) : out_idx;
        fin_nx     = 1'b0;
        scan_inc   = 1'b0;
        scan_clr   = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (layer_0_en) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (!layer_0_en) begin
                    abort = 1'b1;
                end else if (rd_en && last_q) begin
                    // Final pixel read is on the bus; no further reads.
                    state_nx = DRAIN;
                    drain_nx = '0;
                end else if (buf_ready) begin
                    rd_en_nx   = 1'b1;
                    rd_addr_nx = scan_addr;
                    win_nx     = scan_win;
                    last_nx    = scan_last;
                    scan_inc   = 1'b1;
                end
            end
            DRAIN: begin
                if (!layer_0_en) begin
                    abort = 1'b1;
                end else if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) begin
                    state_nx = FIN;
                    fin_nx   = 1'b1;
                end else begin
                    drain_nx = drain_cnt + DRAIN_W'(1);
                end
            end
            FIN: begin
                state_nx   = IDLE;
                out_idx_nx = '0;
                drain_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (abort) begin
            state_nx   = IDLE;
            drain_nx   = '0;
            rd_en_nx   = 1'b0;
            rd_addr_nx = '0;
            win_nx     = 1'b0;
            last_nx    = 1'b0;
            calc_en_nx = 1'b0;
            out_idx_nx = '0;
            scan_clr   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_0_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_0_controller
//  Description : Self-checking bench for layer_0_controller with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_0_controller;

    localparam int N  = 8;
    localparam int K  = 3;
    localparam int PL = 4;
    localparam int N2 = N * N;
    localparam int AW = 6;
    localparam int IW = 6;

    logic          clk;
    logic          rst_n;
    logic          layer_0_en;
    logic          buf_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          calc_en;
    logic [IW-1:0] out_idx;
    logic          layer_0_calc_fin;

    layer_0_controller #(
        .IMAGE_SIZE  (N),
        .KERNEL_SIZE (K),
        .PIPE_LAT    (PL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .layer_0_en       (layer_0_en),
        .buf_ready        (buf_ready),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .calc_en          (calc_en),
        .out_idx          (out_idx),
        .layer_0_calc_fin (layer_0_calc_fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks reads done in the image and the number of
    // cycles elapsed since the final read; fin is due PIPE_LAT+1 cycles
    // after the final read.
    // ------------------------------------------------------------------
    function automatic bit in_window(input int a);
        return ((a / N) >= K - 1) && ((a % N) >= K - 1);
    endfunction

    bit e_rd = 0, e_calc = 0, e_fin = 0, m_busy = 0;
    bit n_rd, n_calc, n_fin;
    int e_addr = 0, n_addr, m_reads = 0, m_tail = -1, m_calcs = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rd = 0; e_calc = 0; e_fin = 0; e_addr = 0;
            m_busy = 0; m_reads = 0; m_tail = -1; m_calcs = 0;
        end else begin
            n_rd   = 0;
            n_fin  = 0;
            n_addr = e_addr;
            n_calc = e_rd && in_window(e_addr);
            if (e_calc) m_calcs++;
            if (m_busy && m_tail != PL + 1 && !layer_0_en) begin
                m_busy = 0; m_reads = 0; m_tail = -1; m_calcs = 0;
                n_calc = 0; n_addr = 0;
            end else if (!m_busy) begin
                if (layer_0_en) begin
                    m_busy = 1; m_reads = 0; m_tail = -1; m_calcs = 0;
                end
            end else if (m_tail == PL + 1) begin
                m_busy = 0; m_calcs = 0;
            end else if (m_tail >= 0) begin
                m_tail++;
                n_fin = (m_tail == PL + 1);
            end else if (buf_ready) begin
                n_rd   = 1;
                n_addr = m_reads;
                m_reads++;
                if (m_reads == N2) m_tail = 0;
            end
            e_rd = n_rd; e_calc = n_calc; e_fin = n_fin; e_addr = n_addr;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus metrics for the literal checks.
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int first_rd = -1, fin_at = -1, n_reads = 0, n_calcs = 0, n_fins = 0;
    int first_calc_addr = -1, first_calc_idx = -1;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("rd_en", 32'(rd_en), 32'(e_rd));
            check("calc_en", 32'(calc_en), 32'(e_calc));
            check("fin", 32'(layer_0_calc_fin), 32'(e_fin));
            if (e_rd)   check("rd_addr", 32'(rd_addr), e_addr);
            if (e_calc) check("out_idx", 32'(out_idx), m_calcs);
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                n_reads++;
            end
            if (calc_en) begin
                if (n_calcs == 0) begin
                    first_calc_addr = int'(prev_addr);
                    first_calc_idx  = int'(out_idx);
                end
                n_calcs++;
            end
            if (layer_0_calc_fin) begin
                n_fins++;
                fin_at = cyc - first_rd;
            end
            prev_addr = rd_addr;
        end
    end

    task automatic clear_metrics();
        first_rd = -1; fin_at = -1; n_reads = 0; n_calcs = 0;
        first_calc_addr = -1; first_calc_idx = -1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fin(input string nm, input int budget);
        int start;
        bit ok;
        start = n_fins;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_fins > start) begin
                ok = 1;
                break;
            end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_read(input string nm, input int a, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rd_en === 1'b1 && int'(rd_addr) == a) begin
                ok = 1;
                break;
            end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        int fins_before;
        bit seen;
        rst_n = 1'b0;
        layer_0_en = 1'b0;
        buf_ready = 1'b0;
        repeat (3) step();
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_calc_en", 32'(calc_en), 32'd0);
        check("reset_out_idx", 32'(out_idx), 32'd0);
        check("reset_fin", 32'(layer_0_calc_fin), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Free-running image: 64 reads, 36 windows, fin in cycle 68.
        clear_metrics();
        layer_0_en = 1'b1;
        buf_ready  = 1'b1;
        wait_fin("img1_timeout", 200);
        layer_0_en = 1'b0;
        check("img1_fin_cycle", fin_at, 68);
        check("img1_reads", n_reads, 64);
        check("img1_calcs", n_calcs, 36);
        check("img1_first_calc_addr", first_calc_addr, 18);
        check("img1_first_calc_idx", first_calc_idx, 0);
        repeat (3) step();

        // Five-cycle stall right after the read of address 20.
        clear_metrics();
        layer_0_en = 1'b1;
        buf_ready  = 1'b1;
        wait_read("stall_reach20", 20, 100);
        buf_ready = 1'b0;
        repeat (5) step();
        check("stall_hold_addr", 32'(rd_addr), 32'd20);
        check("stall_no_read", 32'(rd_en), 32'd0);
        buf_ready = 1'b1;
        wait_fin("stall_timeout", 200);
        layer_0_en = 1'b0;
        check("stall_fin_cycle", fin_at, 73);
        check("stall_reads", n_reads, 64);
        repeat (3) step();

        // Manager running three images with a random-ready buffer.
        fins_before = n_fins;
        layer_0_en = 1'b1;
        for (int img = 0; img < 3; img++) begin
            seen = 0;
            for (int i = 0; i < 500; i++) begin
                buf_ready = ($urandom_range(0, 3) != 0);
                step();
                if (n_fins > fins_before + img) begin
                    seen = 1;
                    break;
                end
            end
            check("multi_fin_seen", 32'(seen), 32'd1);
        end
        layer_0_en = 1'b0;
        repeat (10) step();
        check("multi_fin_count", n_fins - fins_before, 3);
        check("multi_idle_after", 32'(rd_en), 32'd0);

        // Abort at address 30, then restart from address 0.
        fins_before = n_fins;
        layer_0_en = 1'b1;
        buf_ready  = 1'b1;
        wait_read("abort_reach30", 30, 100);
        layer_0_en = 1'b0;
        repeat (3) step();
        check("abort_no_fin", n_fins, fins_before);
        clear_metrics();
        layer_0_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_en === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("restart_seen", 32'(seen), 32'd1);
        check("restart_addr", 32'(rd_addr), 32'd0);
        wait_fin("restart_timeout", 200);
        layer_0_en = 1'b0;
        repeat (3) step();

        // Asynchronous reset while draining.
        fins_before = n_fins;
        layer_0_en = 1'b1;
        buf_ready  = 1'b1;
        wait_read("rst_reach63", 63, 100);
        repeat (2) step();
        rst_n = 1'b0;
        layer_0_en = 1'b0;
        #1;
        check("drain_rst_rd_en", 32'(rd_en), 32'd0);
        check("drain_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("drain_rst_calc_en", 32'(calc_en), 32'd0);
        check("drain_rst_out_idx", 32'(out_idx), 32'd0);
        check("drain_rst_fin", 32'(layer_0_calc_fin), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
        check("drain_rst_no_fin", n_fins, fins_before);

        // Random soak: random ready, occasional enable drops.
        for (int i = 0; i < 800; i++) begin
            buf_ready  = ($urandom_range(0, 3) != 0);
            layer_0_en = ($urandom_range(0, 149) != 0);
            step();
        end
        layer_0_en = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
